gaussian_window_buffer: RTL and testbench
=========================================

// Module: gaussian_window_buffer
// PURPOSE
// - Line-buffer/window stage directly upstream of GaussianConv in the Oriented-FAST ISP.
// - Accepts a raster pixel stream (valid/ready).
// - Stores SIZE-1 previous lines and emits one SIZExSIZE pixel window per accepted
//   pixel that completes a fully in-image window.
// - The window feeds GaussianConv's convolution datapath. Valid-region only: no border padding.
// PARAMETERS
// - SIZE   4'd3  window edge; odd, 3..7
// - PIX_W  8     bits per pixel
// - IMG_W  640   pixels per line (>= SIZE)
// - IMG_H  480   lines per frame (>= SIZE)
// PORTS
// - clk         in   1                  single clock, rising edge
// - rst         in   1                  asynchronous, active-high reset
// - in_valid    in   1                  input pixel valid
// - in_ready    out  1                  stage can accept a pixel
// - in_pixel    in   PIX_W              raster-order pixel
// - in_sof      in   1                  qualifies in_pixel as frame pixel (0,0)
// - out_valid   out  1                  out_window valid
// - out_ready   in   1                  GaussianConv accepts the window
// - out_window  out  SIZE*SIZE*PIX_W    element (i,j) at bits [(i*SIZE+j)*PIX_W +: PIX_W]; i=0 oldest row, j=0 oldest column
// - out_sof     out  1                  first window of frame
// - out_eof     out  1                  last window of frame
// BEHAVIOUR
// - Reset (async, any cycle):
//   - out_valid=0, out_sof=0, out_eof=0, out_window=0.
//   - col=0, row=0.
//   - Line-buffer contents are don't-care. No output window may use pre-reset data.
// - Handshakes:
//   - Input handshake: in_valid && in_ready.
//   - Output handshake: out_valid && out_ready.
//   - in_ready = !out_valid || out_ready (one output register, combinational pass of ready).
// - On each input handshake:
//   - Write in_pixel into the line buffer at column col.
//   - Shift the SIZE column taps into the window register.
//   - Then advance col/row:
//     - col wraps at IMG_W-1, which increments row.
//     - Row wraps at IMG_H-1 back to 0 (frame end).
// - in_sof=1 on a handshake forces the pixel to (0,0), discarding any partial frame (resync).
//   - in_sof on a pixel already at (0,0) is a no-op.
// - Window ready condition: the accepted pixel at (r,c) has r>=SIZE-1 and c>=SIZE-1.
//   - The next cycle: out_valid=1, and out_window holds rows r-SIZE+1..r and cols c-SIZE+1..c.
//   - Latency: 1 cycle, handshake to out_valid.
// - out_sof=1 with the window at (SIZE-1,SIZE-1).
// - out_eof=1 with the window at (IMG_H-1,IMG_W-1).
// - Windows per frame = (IMG_W-SIZE+1)*(IMG_H-SIZE+1).
// - Stall: while out_valid && !out_ready, out_window, out_sof and out_eof hold stable,
//   and in_ready=0. Nothing is lost or duplicated.
// - Output handshake with no new completing pixel: out_valid falls next cycle.
// - Simultaneous output handshake and completing input handshake: out_valid stays 1 and
//   the new window loads. This gives full throughput of 1 pixel/cycle.
// - Column taps at row r:
//   - Line-buffer k (k=0..SIZE-2) supplies row r-SIZE+1+k.
//   - in_pixel supplies row r.
//   - Buffers rotate by write-through: buffer k+1's old value moves into buffer k at the same column.
// - Horizontal window shift register: SIZE columns.
//   - At col=0 the shift is still performed.
//   - Stale left columns are never emitted because c>=SIZE-1 gates out_valid.
// - No arithmetic on pixel values. Counters:
//   - col width $clog2(IMG_W).
//   - row width $clog2(IMG_H).
// STRUCTURE
// - isp_pkg:
//   - typedef logic [PIX_W-1:0] pixel_t.
//   - Default PIX_W, IMG_W, IMG_H, SIZE constants.
//   - Window-index helper function (i,j) -> bit offset.
// - Sub-module line_buffer_ram:
//   - One line of IMG_W x PIX_W.
//   - Synchronous read-before-write at a shared address.
//   - Enable = input handshake.
//   - SIZE-1 instances via generate.
// - Top holds counters, tap rotation, window shift register and output register.
// TESTING
// - Bench config: SIZE=3, IMG_W=5, IMG_H=4. Pixel value = {row[3:0],col[3:0]}.
// - 1. Full frame, out_ready=1, in_valid=1 every cycle:
//   - Exactly 6 windows.
//   - First window one cycle after pixel 0x22 is accepted: out_sof=1, (0,0)=0x00, (1,1)=0x11, (2,2)=0x22.
//   - Last window: out_eof=1, (2,2)=0x34, (0,0)=0x12.
// - 2. Backpressure: drop out_ready for 3 cycles while out_valid=1:
//   - in_ready=0 and out_window stable for those 3 cycles.
//   - Resume with no gaps or duplicates; all 6 windows still correct in order.
// - 3. Bubbly input (in_valid toggles 1,0,1,0):
//   - Same 6 windows, same contents.
//   - out_valid only one cycle after completing handshakes.
// - 4. Resync: assert in_sof on pixel 7 of frame 1, then send a full frame:
//   - Exactly 6 windows, first with out_sof=1 and (0,0)=0x00.
//   - No window mixes old-frame data.
// - 5. Reset mid-frame: raise rst for 2 cycles after 12 pixels:
//   - out_valid=0 immediately (async).
//   - A following full frame produces the 6 correct windows.
// - 6. Back-to-back frames without gap: 12 windows total.
//   - out_eof on the 6th, out_sof on the 7th.
//   - Window 7 (0,0)=0x00.

Source files
------------

// File: rtl/isp_pkg.sv
// isp_pkg: shared pixel type, default geometry and window bit-offset helper for the ISP window stages
package isp_pkg;

    localparam int DEF_SIZE  = 3;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef logic [DEF_PIX_W-1:0] pixel_t;

    // Bit offset of window element (i,j): i = row (0 oldest), j = column (0 oldest)
    function automatic int win_off(input int i, input int j, input int size, input int pix_w);
        return (i * size + j) * pix_w;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// line_buffer_ram: one image line of storage, read-before-write at a shared address
//   clk      in   clock, rising edge
//   en       in   write enable (one accepted pixel)
//   addr     in   column address, shared by read and write
//   wr_data  in   word stored at addr on an enabled edge
//   rd_data  out  word currently at addr, i.e. the value the enabled edge replaces
module line_buffer_ram import isp_pkg::*; #(
    parameter int DEPTH = DEF_IMG_W,
    parameter int PIX_W = DEF_PIX_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // The old word is presented during the cycle and captured downstream on the
    // same edge that overwrites it.
    assign rd_data = mem[addr];

    always_ff @(posedge clk)
        if (en)
            mem[addr] <= wr_data;

endmodule

// File: rtl/gaussian_window_buffer.sv
// gaussian_window_buffer: raster pixel stream to SIZE x SIZE valid-region windows for GaussianConv
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    in   pixel valid          in_ready   out  stage accepts a pixel
//   in_pixel    in   raster pixel         in_sof     in   pixel is frame (0,0)
//   out_valid   out  window valid         out_ready  in   consumer accepts the window
//   out_window  out  element (i,j) at [(i*SIZE+j)*PIX_W +: PIX_W], i=0 oldest row, j=0 oldest column
//   out_sof     out  first window of frame
//   out_eof     out  last window of frame
module gaussian_window_buffer import isp_pkg::*; #(
    parameter int SIZE  = DEF_SIZE,
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIX_W-1:0]            in_pixel,
    input  logic                        in_sof,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SIZE*SIZE*PIX_W-1:0]  out_window,
    output logic                        out_sof,
    output logic                        out_eof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = SIZE * SIZE * PIX_W;
    localparam int LW = SIZE * PIX_W;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_EDGE = CW'(SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_EDGE = RW'(SIZE - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic [WW-1:0] win_q, win_d;
    logic          in_fire, complete;

    logic [SIZE-2:0][PIX_W-1:0] rd_tap;
    logic [SIZE-1:0][PIX_W-1:0] col_tap;

    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    // in_sof relocates the pixel to (0,0); a partial frame is simply abandoned.
    assign col_cur  = in_sof ? '0 : col_q;
    assign row_cur  = in_sof ? '0 : row_q;
    assign complete = (row_cur >= ROW_EDGE) && (col_cur >= COL_EDGE);

    // Buffer k holds row r-SIZE+1+k; each write pushes the next-newer row down one buffer.
    for (genvar k = 0; k < SIZE - 1; k++) begin : g_line
        logic [PIX_W-1:0] wr;
        if (k == SIZE - 2) begin : g_newest
            assign wr = in_pixel;
        end else begin : g_older
            assign wr = rd_tap[k+1];
        end
        line_buffer_ram #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_ram (
            .clk     (clk),
            .en      (in_fire),
            .addr    (col_cur),
            .wr_data (wr),
            .rd_data (rd_tap[k])
        );
    end

    always_comb begin
        col_tap = '0;
        for (int i = 0; i < SIZE - 1; i++)
            col_tap[i] = rd_tap[i];
        col_tap[SIZE-1] = in_pixel;
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q && !out_ready;
        sof_d   = sof_q;
        eof_d   = eof_q;
        win_d   = win_q;
        if (in_fire) begin
            col_d   = (col_cur == COL_LAST) ? '0 : col_cur + 1'b1;
            row_d   = (col_cur != COL_LAST) ? row_cur : (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            valid_d = complete;
            if (complete) begin
                sof_d = (row_cur == ROW_EDGE) && (col_cur == COL_EDGE);
                eof_d = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
            end
            // Shift every row one column older; stale columns after a line wrap are
            // flushed before the column gate lets a window out.
            for (int i = 0; i < SIZE; i++)
                win_d[win_off(i, 0, SIZE, PIX_W) +: LW] =
                    {col_tap[i], win_q[win_off(i, 1, SIZE, PIX_W) +: LW - PIX_W]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            win_q   <= win_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_window = win_q;
    assign out_sof    = sof_q;
    assign out_eof    = eof_q;

endmodule

// File: tb/tb_gaussian_window_buffer.sv
// tb_gaussian_window_buffer: directed checks of gaussian_window_buffer on a 5x4 image with 3x3 windows
module tb_gaussian_window_buffer;
    import isp_pkg::*;

    localparam int SIZE  = 3;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int WW    = SIZE * SIZE * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          out_ready = 1'b1;
    pixel_t        in_pixel = '0;
    logic          in_ready, out_valid, out_sof, out_eof;
    logic [WW-1:0] out_window;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_win   = 0;
    logic [WW+1:0] exp_q [$];
    logic [WW+1:0] mon_e;
    logic [WW-1:0] first_win, last_win, seventh_win;

    always #5 clk = ~clk;

    gaussian_window_buffer #(.SIZE(SIZE), .PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_sof    (out_sof),
        .out_eof    (out_eof)
    );

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pixel_t pix(input int r, input int c);
        return pixel_t'(((r & 15) << 4) | (c & 15));
    endfunction

    function automatic logic [WW-1:0] exp_win(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                w[(i * SIZE + j) * 8 +: 8] = pix(r - SIZE + 1 + i, c - SIZE + 1 + j);
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("spurious_window", WW'(out_valid), WW'(0));
            else begin
                mon_e = exp_q.pop_front();
                check("window", out_window, mon_e[WW+1:2]);
                check("sof", WW'(out_sof), WW'(mon_e[1]));
                check("eof", WW'(out_eof), WW'(mon_e[0]));
                if (n_win == 0) first_win = out_window;
                if (n_win == 6) seventh_win = out_window;
                last_win = out_window;
                n_win++;
            end
        end
    end

    task automatic send(input pixel_t p, input logic s, input logic done);
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = s;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("in_ready_timeout", WW'(in_ready), WW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("latency", WW'(out_valid), WW'(done));
    endtask

    task automatic send_frame(input logic bubble);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                logic done;
                done = (r >= SIZE - 1) && (c >= SIZE - 1);
                if (done)
                    exp_q.push_back({exp_win(r, c), r == SIZE - 1 && c == SIZE - 1, r == IMG_H - 1 && c == IMG_W - 1});
                send(pix(r, c), r == 0 && c == 0, done);
                if (bubble) begin
                    @(posedge clk);
                    #1;
                    check("bubble_idle", WW'(out_valid), WW'(0));
                end
            end
    endtask

    task automatic backpressure();
        logic [WW-1:0] cap;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        check("bp_wait", WW'(out_valid), WW'(1));
        out_ready = 1'b0;
        cap = out_window;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", WW'(in_ready), WW'(0));
            check("bp_hold", out_window, cap);
            check("bp_valid", WW'(out_valid), WW'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic finish_test(input string tag, input int n);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, WW'(n_win), WW'(n));
        check({tag, "_drained"}, WW'(exp_q.size()), WW'(0));
        n_win = 0;
    endtask

    initial begin
        #12;
        check("rst_valid", WW'(out_valid), WW'(0));
        check("rst_sof", WW'(out_sof), WW'(0));
        check("rst_eof", WW'(out_eof), WW'(0));
        check("rst_window", out_window, WW'(0));
        check("rst_in_ready", WW'(in_ready), WW'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // full-rate frame
        send_frame(1'b0);
        finish_test("full", 6);
        check("first_00", WW'(first_win[7:0]), WW'(8'h00));
        check("first_11", WW'(first_win[39:32]), WW'(8'h11));
        check("first_22", WW'(first_win[71:64]), WW'(8'h22));
        check("last_22", WW'(last_win[71:64]), WW'(8'h34));
        check("last_00", WW'(last_win[7:0]), WW'(8'h12));

        // consumer stalls for three cycles mid-frame
        fork
            send_frame(1'b0);
            backpressure();
        join
        finish_test("stall", 6);

        // one idle cycle after every pixel
        send_frame(1'b1);
        finish_test("bubble", 6);

        // seven pixels of a frame carrying foreign values, then resync
        for (int i = 0; i < 7; i++)
            send(pixel_t'(8'hA0 + i), i == 0, 1'b0);
        send_frame(1'b0);
        finish_test("resync", 6);
        check("resync_first_00", WW'(first_win[7:0]), WW'(8'h00));

        // reset while a window is held
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++)
            send(pix(i / IMG_W, i % IMG_W), i == 0, i == 12);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", WW'(out_valid), WW'(0));
        check("async_rst_window", out_window, WW'(0));
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(1'b0);
        finish_test("post_rst", 6);

        // two frames back to back
        send_frame(1'b0);
        send_frame(1'b0);
        finish_test("b2b", 12);
        check("b2b_win7_00", WW'(seventh_win[7:0]), WW'(8'h00));
        check("b2b_last_00", WW'(last_win[7:0]), WW'(8'h12));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
